data_cache_ctrl: RTL and testbench

- Blocking, direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the core's MEM stage (64-bit word port) and the memory arbiter's data side (512-bit line port).
- Serves one request at a time.
- Hits complete in one cycle; misses perform an optional dirty-line writeback followed by a line fill.

---
 rtl/data_cache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: blocking, direct-mapped, write-back, write-allocate L1 data cache.
//
// Sits between the core MEM stage (64-bit word port) and the memory arbiter data
// side (512-bit line port). One request is served at a time. Hits complete with
// done one cycle after enable is sampled. Misses optionally write back a dirty
// victim and then fill the line.
//
// Parameters:
//   SETS      number of 64-byte lines (power of two, at least 2)
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   enable    request valid, held by the requester until done
//   wenable   1 = write, 0 = read
//   addr      byte address, addr[2:0] ignored
//   rdata     read data, valid in the done cycle
//   wdata     write data
//   done      one-cycle completion pulse
//   drequest  memory request valid, held until ddone
//   dwrenable 1 = line writeback, 0 = line fill
//   daddr     line address, bits [5:0] zero
//   drdata    fill data, valid with ddone
//   dwdata    writeback line data
//   ddone     memory completion pulse
module data_cache_ctrl #(
    parameter int unsigned SETS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         wenable,
    input  logic [63:0]  addr,
    output logic [63:0]  rdata,
    input  logic [63:0]  wdata,
    output logic         done,
    output logic         drequest,
    output logic         dwrenable,
    output logic [63:0]  daddr,
    input  logic [511:0] drdata,
    output logic [511:0] dwdata,
    input  logic         ddone
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 64 - 6 - IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StWb,
        StFill,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]  valid_q, valid_d;
    logic [SETS-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [511:0]     data_q [SETS];

    logic         drequest_q, drequest_d;
    logic         dwrenable_q, dwrenable_d;
    logic [63:0]  daddr_q, daddr_d;
    logic [511:0] dwdata_q, dwdata_d;
    logic [63:0]  rdata_q, rdata_d;

    logic             tag_we;
    logic             data_we;
    logic [511:0]     data_wline;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       req_word;
    logic [8:0]       word_base;
    logic [511:0]     cur_line;
    logic             hit;
    logic             unused_addr;

    assign req_idx     = addr[6 +: IDX_W];
    assign req_tag     = addr[63 -: TAG_W];
    assign req_word    = addr[5:3];
    assign word_base   = {req_word, 6'b0};
    assign cur_line    = data_q[req_idx];
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr = ^addr[2:0];

    function automatic logic [511:0] merge_word(input logic [511:0] line,
                                                input logic [8:0]   base,
                                                input logic [63:0]  word);
        logic [511:0] res;
        res = line;
        res[base +: 64] = word;
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        drequest_d  = drequest_q;
        dwrenable_d = dwrenable_q;
        daddr_d     = daddr_q;
        dwdata_d    = dwdata_q;
        rdata_d     = rdata_q;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        data_wline  = merge_word(cur_line, word_base, wdata);

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    if (hit) begin
                        if (wenable) begin
                            data_we          = 1'b1;
                            dirty_d[req_idx] = 1'b1;
                        end else begin
                            rdata_d = cur_line[word_base +: 64];
                        end
                        state_d = StDone;
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d     = StWb;
                        drequest_d  = 1'b1;
                        dwrenable_d = 1'b1;
                        daddr_d     = {tag_q[req_idx], req_idx, 6'b0};
                        dwdata_d    = cur_line;
                    end else begin
                        state_d     = StFill;
                        drequest_d  = 1'b1;
                        dwrenable_d = 1'b0;
                        daddr_d     = {addr[63:6], 6'b0};
                    end
                end
            end
            StWb: begin
                if (ddone) begin
                    // Victim is now safe in memory; switch straight to the fill request.
                    dirty_d[req_idx] = 1'b0;
                    state_d          = StFill;
                    dwrenable_d      = 1'b0;
                    daddr_d          = {addr[63:6], 6'b0};
                end
            end
            StFill: begin
                if (ddone) begin
                    // Install the line and apply the pending access in the same edge.
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = wenable;
                    tag_we           = 1'b1;
                    data_we          = 1'b1;
                    data_wline       = wenable ? merge_word(drdata, word_base, wdata) : drdata;
                    if (!wenable) begin
                        rdata_d = drdata[word_base +: 64];
                    end
                    drequest_d  = 1'b0;
                    dwrenable_d = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            drequest_q  <= 1'b0;
            dwrenable_q <= 1'b0;
            daddr_q     <= '0;
            dwdata_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            drequest_q  <= drequest_d;
            dwrenable_q <= dwrenable_d;
            daddr_q     <= daddr_d;
            dwdata_q    <= dwdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Tag and line storage are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
        if (data_we) begin
            data_q[req_idx] <= data_wline;
        end
    end

    assign done      = (state_q == StDone);
    assign drequest  = drequest_q;
    assign dwrenable = dwrenable_q;
    assign daddr     = daddr_q;
    assign dwdata    = dwdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
module tb_data_cache_ctrl;

    localparam int unsigned SETS = 64;

    typedef logic [511:0] line_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         wenable = 1'b0;
    logic [63:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic [511:0] drdata = '0;
    logic         ddone = 1'b0;
    logic [63:0]  rdata;
    logic         done;
    logic         drequest;
    logic         dwrenable;
    logic [63:0]  daddr;
    logic [511:0] dwdata;

    int checks = 0;
    int errors = 0;

    // Memory contents and the architecturally visible data (latest writes).
    line_t       mem    [logic [63:0]];
    line_t       golden [logic [63:0]];
    // Which line each set holds, and whether it differs from memory.
    bit          mvalid [SETS];
    bit          mdirty [SETS];
    logic [63:0] mline  [SETS];

    data_cache_ctrl #(.SETS(SETS)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wenable   (wenable),
        .addr      (addr),
        .rdata     (rdata),
        .wdata     (wdata),
        .done      (done),
        .drequest  (drequest),
        .dwrenable (dwrenable),
        .daddr     (daddr),
        .drdata    (drdata),
        .dwdata    (dwdata),
        .ddone     (ddone)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t init_line(input logic [63:0] la);
        line_t l;
        for (int w = 0; w < 8; w++) begin
            l[w*64 +: 64] = {la[31:0], 32'hC0DE_0000 | 32'(w)};
        end
        return l;
    endfunction

    function automatic line_t mem_line(input logic [63:0] la);
        if (mem.exists(la)) return mem[la];
        return init_line(la);
    endfunction

    function automatic line_t cur_line(input logic [63:0] la);
        if (golden.exists(la)) return golden[la];
        return mem_line(la);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_wait(input int lat);
        repeat (lat) begin
            tick();
            check_eq("req_hold", drequest, 1'b1);
            check_eq("no_early_done", done, 1'b0);
        end
    endtask

    task automatic do_req(input bit we, input logic [63:0] a, input logic [63:0] d);
        logic [63:0] la;
        logic [63:0] victim;
        int          idx;
        int          w;
        bit          hit;
        bit          wb;
        line_t       exp_line;
        la       = {a[63:6], 6'b0};
        idx      = int'(a[11:6]);
        w        = int'(a[5:3]);
        hit      = mvalid[idx] && (mline[idx] == la);
        wb       = !hit && mvalid[idx] && mdirty[idx];
        victim   = mline[idx];
        exp_line = cur_line(la);
        if (we) exp_line[w*64 +: 64] = d;

        @(negedge clk);
        enable  = 1'b1;
        wenable = we;
        addr    = a;
        wdata   = d;
        tick();
        if (hit) begin
            check_eq("hit_done", done, 1'b1);
            check_eq("hit_no_req", drequest, 1'b0);
        end else begin
            check_eq("miss_req", drequest, 1'b1);
            check_eq("miss_no_done", done, 1'b0);
            if (wb) begin
                check_eq("wb_dir", dwrenable, 1'b1);
                check_eq("wb_addr", daddr, victim);
                check_eq("wb_data", dwdata, cur_line(victim));
                mem_wait($urandom_range(0, 3));
                @(negedge clk);
                ddone  = 1'b1;
                drdata = {16{$urandom}};
                tick();
                mem[victim] = cur_line(victim);
                check_eq("fill_after_wb", drequest, 1'b1);
                check_eq("fill_dir", dwrenable, 1'b0);
                check_eq("fill_addr", daddr, la);
                @(negedge clk);
                ddone = 1'b0;
            end else begin
                check_eq("fill_dir", dwrenable, 1'b0);
                check_eq("fill_addr", daddr, la);
            end
            mem_wait($urandom_range(0, 3));
            @(negedge clk);
            ddone  = 1'b1;
            drdata = mem_line(la);
            tick();
            check_eq("fill_done", done, 1'b1);
            check_eq("fill_req_drop", drequest, 1'b0);
        end
        if (!we) check_eq("rdata", rdata, exp_line[w*64 +: 64]);
        @(negedge clk);
        enable = 1'b0;
        ddone  = 1'b0;
        drdata = '0;
        tick();
        check_eq("done_pulse", done, 1'b0);

        golden[la]  = exp_line;
        mvalid[idx] = 1'b1;
        mline[idx]  = la;
        mdirty[idx] = hit ? (mdirty[idx] | we) : we;
    endtask

    task automatic clear_model();
        for (int i = 0; i < SETS; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        golden.delete();
    endtask

    task automatic reset_during_fill(input logic [63:0] a);
        @(negedge clk);
        enable  = 1'b1;
        wenable = 1'b0;
        addr    = a;
        tick();
        check_eq("rst_pre_req", drequest, 1'b1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_req_drop", drequest, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_dwren", dwrenable, 1'b0);
        check_eq("rst_daddr", daddr, 64'h0);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        clear_model();
        // Late completion from the aborted transaction must be ignored.
        @(negedge clk);
        ddone  = 1'b1;
        drdata = {16{32'hBAD0_BAD0}};
        tick();
        check_eq("stray_ddone_req", drequest, 1'b0);
        check_eq("stray_ddone_done", done, 1'b0);
        @(negedge clk);
        ddone  = 1'b0;
        drdata = '0;
        tick();
        check_eq("stray_ddone_idle", done, 1'b0);
    endtask

    initial begin
        logic [63:0] tags [4];
        line_t       l40;
        tags[0] = 64'h0;
        tags[1] = 64'h1000;
        tags[2] = 64'h2000;
        tags[3] = 64'hFFFF_FFFF_FFFF_F000;

        l40 = init_line(64'h40);
        l40[127:64] = 64'h1111;
        mem[64'h40] = l40;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_drequest", drequest, 1'b0);
        check_eq("reset_dwrenable", dwrenable, 1'b0);
        check_eq("reset_daddr", daddr, 64'h0);
        check_eq("reset_dwdata", dwdata, '0);
        check_eq("reset_rdata", rdata, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        do_req(1'b0, 64'h48, 64'h0);
        check_eq("plan_fill_word1", rdata, 64'h1111);
        do_req(1'b0, 64'h48, 64'h0);
        do_req(1'b1, 64'h48, 64'hDEAD_BEEF);
        do_req(1'b0, 64'h48, 64'h0);
        check_eq("plan_hit_write", rdata, 64'hDEAD_BEEF);
        do_req(1'b0, 64'h1048, 64'h0);
        check_eq("plan_wb_mem", mem[64'h40][127:64], 64'hDEAD_BEEF);
        do_req(1'b1, 64'h2000, 64'h5);
        do_req(1'b0, 64'h2000, 64'h0);
        check_eq("plan_write_miss", rdata, 64'h5);
        do_req(1'b0, 64'h3000, 64'h0);

        reset_during_fill(64'h7000_0140);
        do_req(1'b0, 64'h7000_0140, 64'h0);

        for (int n = 0; n < 300; n++) begin
            logic [63:0] a;
            logic [63:0] d;
            a = tags[$urandom_range(0, 3)]
                | (64'($urandom_range(0, 7)) << 6)
                | (64'($urandom_range(0, 7)) << 3)
                | 64'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            do_req(1'($urandom_range(0, 1)), a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
